// File: rtl/pifo_calendar_sorted_v2.sv
// Shift-register PIFO calendar: sorted descriptor queue with one insert and one pop per cycle.
// Define PIFO_CALENDAR_RANK_WRAP_EN for serial-number (wrap-aware) rank ordering.
module pifo_calendar_sorted_v2 #(
  parameter int DEPTH             = 512,
  parameter int INDEX_WIDTH       = 9,
  parameter int RANK_WIDTH        = 18,
  parameter int BUFFER_ADDR_WIDTH = 12,
  parameter int ELEM_WIDTH        = 32,
  parameter int DROP_CNT_WIDTH    = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [ELEM_WIDTH-1:0]        s_axis_pifo_info,
  input  logic                         s_axis_insert_en,
  input  logic                         s_axis_pop_en,
  output logic                         m_axis_valid,
  output logic [ELEM_WIDTH-1:0]        m_axis_pifo_info,
  output logic [BUFFER_ADDR_WIDTH-1:0] m_axis_buffer_addr,
  output logic                         m_axis_calendar_full,
  output logic                         m_axis_calendar_empty,
  output logic [INDEX_WIDTH:0]         m_axis_calendar_count,
  output logic [DROP_CNT_WIDTH-1:0]    drop_count,
  input  logic                         cpu_rd_valid,
  input  logic [INDEX_WIDTH-1:0]       cpu_rd_addr,
  output logic                         cpu_rd_result_valid,
  output logic [ELEM_WIDTH-1:0]        cpu_rd_result
);
  localparam int CW   = INDEX_WIDTH + 1;
  localparam int RLSB = BUFFER_ADDR_WIDTH;
  localparam int RMSB = BUFFER_ADDR_WIDTH + RANK_WIDTH - 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [ELEM_WIDTH-1:0]     r_slot [DEPTH];
  logic [ELEM_WIDTH-1:0]     w_slot_next [DEPTH];
  logic [CW-1:0]             r_count;
  logic [DROP_CNT_WIDTH-1:0] r_drop;
  logic                      r_valid;
  logic [ELEM_WIDTH-1:0]     r_info;
  logic                      r_rd_valid;
  logic [ELEM_WIDTH-1:0]     r_rd_result;

  logic [DEPTH-1:0]          w_before;
  logic [CW-1:0]             w_ip;
  logic [CW-1:0]             w_pos;
  logic                      w_full;
  logic                      w_pop;
  logic                      w_ins;
  logic                      w_drop;
  logic [ELEM_WIDTH-1:0]     w_elem;
  logic [RANK_WIDTH-1:0]     w_new_rank;

  function automatic logic precedes(input logic [RANK_WIDTH-1:0] a,
                                    input logic [RANK_WIDTH-1:0] b);
`ifdef PIFO_CALENDAR_RANK_WRAP_EN
    logic [RANK_WIDTH-1:0] d;
    d = a - b;
    return d[RANK_WIDTH-1];
`else
    return a < b;
`endif
  endfunction

  assign w_full     = (r_count == FULL_CNT);
  assign w_pop      = s_axis_pop_en && (r_count != '0);
  // A pop in the same cycle frees a slot, so a full calendar still accepts.
  assign w_ins      = s_axis_insert_en && (!w_full || w_pop);
  assign w_drop     = s_axis_insert_en && w_full && !w_pop;
  assign w_elem     = {1'b1, s_axis_pifo_info[ELEM_WIDTH-2:0]};
  assign w_new_rank = s_axis_pifo_info[RMSB:RLSB];

  // Strict precedence keeps equal ranks in arrival order.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_before[INDEX_WIDTH'(i)] = !r_slot[INDEX_WIDTH'(i)][ELEM_WIDTH-1] ||
                                  precedes(w_new_rank, r_slot[INDEX_WIDTH'(i)][RMSB:RLSB]);
    end
    w_ip = FULL_CNT;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_before[INDEX_WIDTH'(i)]) w_ip = CW'(i);
    end
  end

  assign w_pos = (w_ip == '0) ? '0 : w_ip - CW'(1);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_slot_next[INDEX_WIDTH'(i)] = r_slot[INDEX_WIDTH'(i)];
      if (w_pop && w_ins) begin
        if (CW'(i) < w_pos)
          w_slot_next[INDEX_WIDTH'(i)] = r_slot[INDEX_WIDTH'(i + 1)];
        else if (CW'(i) == w_pos)
          w_slot_next[INDEX_WIDTH'(i)] = w_elem;
      end else if (w_pop) begin
        w_slot_next[INDEX_WIDTH'(i)] = (i == DEPTH - 1) ? '0 : r_slot[INDEX_WIDTH'(i + 1)];
      end else if (w_ins) begin
        if (CW'(i) == w_ip)
          w_slot_next[INDEX_WIDTH'(i)] = w_elem;
        else if (CW'(i) > w_ip)
          w_slot_next[INDEX_WIDTH'(i)] = r_slot[INDEX_WIDTH'(i + DEPTH - 1)];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) r_slot[INDEX_WIDTH'(i)] <= '0;
      r_count     <= '0;
      r_drop      <= '0;
      r_valid     <= 1'b0;
      r_info      <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_result <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) r_slot[INDEX_WIDTH'(i)] <= w_slot_next[INDEX_WIDTH'(i)];
      r_count <= r_count + CW'(w_ins) - CW'(w_pop);
      if (w_drop && (r_drop != '1)) r_drop <= r_drop + DROP_CNT_WIDTH'(1);
      r_valid <= w_pop;
      if (w_pop) r_info <= r_slot[0];
      r_rd_valid <= cpu_rd_valid;
      if (cpu_rd_valid)
        r_rd_result <= ({1'b0, cpu_rd_addr} < r_count) ? r_slot[cpu_rd_addr] : '0;
    end
  end

  assign m_axis_valid          = r_valid;
  assign m_axis_pifo_info      = r_info;
  assign m_axis_buffer_addr    = r_info[BUFFER_ADDR_WIDTH-1:0];
  assign m_axis_calendar_full  = w_full;
  assign m_axis_calendar_empty = (r_count == '0);
  assign m_axis_calendar_count = r_count;
  assign drop_count            = r_drop;
  assign cpu_rd_result_valid   = r_rd_valid;
  assign cpu_rd_result         = r_rd_result;
endmodule

// File: tb/tb_pifo_calendar_sorted_v2.sv
// Self-checking bench for pifo_calendar_sorted_v2: directed plan steps plus random traffic
// checked against a queue-based reference model.
module tb_pifo_calendar_sorted_v2;
  localparam int DEPTH = 8;
  localparam int IW    = 3;
  localparam int RW    = 18;
  localparam int BA    = 12;
  localparam int EW    = 2 + RW + BA;
  localparam int DW    = 16;

  logic          clk;
  logic          rstn;
  logic [EW-1:0] s_axis_pifo_info;
  logic          s_axis_insert_en;
  logic          s_axis_pop_en;
  logic          m_axis_valid;
  logic [EW-1:0] m_axis_pifo_info;
  logic [BA-1:0] m_axis_buffer_addr;
  logic          m_axis_calendar_full;
  logic          m_axis_calendar_empty;
  logic [IW:0]   m_axis_calendar_count;
  logic [DW-1:0] drop_count;
  logic          cpu_rd_valid;
  logic [IW-1:0] cpu_rd_addr;
  logic          cpu_rd_result_valid;
  logic [EW-1:0] cpu_rd_result;

  pifo_calendar_sorted_v2 #(
    .DEPTH(DEPTH), .INDEX_WIDTH(IW), .RANK_WIDTH(RW),
    .BUFFER_ADDR_WIDTH(BA), .ELEM_WIDTH(EW), .DROP_CNT_WIDTH(DW)
  ) dut (
    .clk(clk), .rstn(rstn),
    .s_axis_pifo_info(s_axis_pifo_info), .s_axis_insert_en(s_axis_insert_en),
    .s_axis_pop_en(s_axis_pop_en), .m_axis_valid(m_axis_valid),
    .m_axis_pifo_info(m_axis_pifo_info), .m_axis_buffer_addr(m_axis_buffer_addr),
    .m_axis_calendar_full(m_axis_calendar_full), .m_axis_calendar_empty(m_axis_calendar_empty),
    .m_axis_calendar_count(m_axis_calendar_count), .drop_count(drop_count),
    .cpu_rd_valid(cpu_rd_valid), .cpu_rd_addr(cpu_rd_addr),
    .cpu_rd_result_valid(cpu_rd_result_valid), .cpu_rd_result(cpu_rd_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: the calendar as an ordered queue of descriptors.
  logic [EW-1:0] mq[$];
  logic [DW-1:0] m_drop;
  logic          m_valid;
  logic [EW-1:0] m_info;
  logic          m_rd_valid;
  logic [EW-1:0] m_rd;

  logic [BA-1:0] exp_addr [4] = '{12'd2, 12'd4, 12'd1, 12'd3};
  logic [BA-1:0] wrap_first;

  function automatic logic prec(input logic [RW-1:0] a, input logic [RW-1:0] b);
`ifdef PIFO_CALENDAR_RANK_WRAP_EN
    int diff;
    diff = (int'(a) - int'(b) + (1 << RW)) % (1 << RW);
    return diff >= (1 << (RW - 1));
`else
    return int'(a) < int'(b);
`endif
  endfunction

  function automatic logic [EW-1:0] mk(input logic [RW-1:0] r, input logic [BA-1:0] a);
    return {2'b00, r, a};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_drop = '0; m_valid = 1'b0; m_info = '0; m_rd_valid = 1'b0; m_rd = '0;
  endtask

  task automatic m_insert(input logic [EW-1:0] e);
    int j;
    j = mq.size();
    for (int k = 0; k < mq.size(); k++) begin
      if (prec(e[BA+RW-1:BA], mq[k][BA+RW-1:BA])) begin
        j = k;
        break;
      end
    end
    mq.insert(j, e);
  endtask

  task automatic check_all();
    check("valid", m_axis_valid, m_valid);
    check("info", m_axis_pifo_info, m_info);
    check("baddr", m_axis_buffer_addr, m_info[BA-1:0]);
    check("count", m_axis_calendar_count, mq.size());
    check("full", m_axis_calendar_full, mq.size() == DEPTH);
    check("empty", m_axis_calendar_empty, mq.size() == 0);
    check("drop", drop_count, m_drop);
    check("rd_valid", cpu_rd_result_valid, m_rd_valid);
    check("rd_data", cpu_rd_result, m_rd);
  endtask

  task automatic cycle(input logic ins, input logic [EW-1:0] info, input logic pop,
                       input logic rd, input logic [IW-1:0] ra);
    logic [EW-1:0] e;
    e = {1'b1, info[EW-2:0]};
    m_rd_valid = rd;
    if (rd) m_rd = (int'(ra) < mq.size()) ? mq[ra] : '0;
    m_valid = pop && (mq.size() > 0);
    if (m_valid) begin
      m_info = mq.pop_front();
      if (ins) m_insert(e);
    end else if (ins) begin
      if (mq.size() == DEPTH) begin
        if (m_drop != '1) m_drop++;
      end else m_insert(e);
    end
    s_axis_insert_en = ins; s_axis_pifo_info = info; s_axis_pop_en = pop;
    cpu_rd_valid = rd; cpu_rd_addr = ra;
    @(posedge clk);
    #1;
    s_axis_insert_en = 1'b0; s_axis_pop_en = 1'b0; cpu_rd_valid = 1'b0;
    check_all();
    $display("t=%0t ins=%0d pop=%0d rd=%0d cnt=%0d valid=%0d out=%0h", $time, ins, pop, rd,
             m_axis_calendar_count, m_axis_valid, m_axis_pifo_info);
  endtask

  task automatic rand_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      logic [EW-1:0] info;
      info = {2'($urandom), RW'($urandom_range(0, 2000)), BA'($urandom)};
      cycle($urandom_range(0, 9) < 6, info, $urandom_range(0, 9) < 4,
            $urandom_range(0, 9) < 3, IW'($urandom));
    end
  endtask

  initial begin
    rstn = 1'b0; s_axis_pifo_info = '0; s_axis_insert_en = 1'b0; s_axis_pop_en = 1'b0;
    cpu_rd_valid = 1'b0; cpu_rd_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rstn = 1'b1;

    // Sort order with FIFO ties
    cycle(1, mk(5, 1), 0, 0, 0);
    cycle(1, mk(2, 2), 0, 0, 0);
    cycle(1, mk(9, 3), 0, 0, 0);
    cycle(1, mk(2, 4), 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cycle(0, '0, 1, 0, 0);
      check("sort_valid", m_axis_valid, 1'b1);
      check("sort_addr", m_axis_buffer_addr, exp_addr[k]);
      cycle(0, '0, 0, 0, 0);
    end
    check("sort_empty", m_axis_calendar_empty, 1'b1);

    // Full and drop, then insert+pop while full
    for (int r = 0; r < 9; r++) cycle(1, mk(RW'(r), BA'(r + 16)), 0, 0, 0);
    check("full_flag", m_axis_calendar_full, 1'b1);
    check("full_count", m_axis_calendar_count, 4'd8);
    check("full_drop", drop_count, 16'd1);
    cycle(1, mk(0, 100), 1, 0, 0);
    check("fullpop_rank", m_axis_pifo_info[BA+RW-1:BA], 18'd0);
    check("fullpop_count", m_axis_calendar_count, 4'd8);
    check("fullpop_drop", drop_count, 16'd1);
    for (int k = 0; k < 8; k++) cycle(0, '0, 1, 1, 0);

    // Simultaneous insert+pop
    cycle(1, mk(10, 5), 0, 0, 0);
    cycle(1, mk(20, 6), 0, 0, 0);
    cycle(1, mk(5, 7), 1, 0, 0);
    check("sim_out", m_axis_pifo_info[BA+RW-1:BA], 18'd10);
    cycle(0, '0, 0, 1, 0);
    check("sim_rd0", cpu_rd_result[BA+RW-1:BA], 18'd5);
    cycle(0, '0, 0, 1, 1);
    check("sim_rd1", cpu_rd_result[BA+RW-1:BA], 18'd20);
    cycle(0, '0, 1, 0, 0);
    cycle(0, '0, 1, 0, 0);

    // Rank wrap
`ifdef PIFO_CALENDAR_RANK_WRAP_EN
    wrap_first = 12'hA;
`else
    wrap_first = 12'hB;
`endif
    cycle(1, mk(18'h3FFF0, 12'hA), 0, 0, 0);
    cycle(1, mk(18'h00010, 12'hB), 0, 0, 0);
    cycle(0, '0, 1, 0, 0);
    check("wrap_first", m_axis_buffer_addr, wrap_first);
    cycle(0, '0, 1, 0, 0);

    // Empty pop and out-of-range CPU read
    cycle(0, '0, 1, 0, 0);
    check("emptypop_valid", m_axis_valid, 1'b0);
    check("emptypop_count", m_axis_calendar_count, 4'd0);
    cycle(1, mk(7, 8), 0, 0, 0);
    cycle(1, mk(3, 9), 0, 0, 0);
    cycle(0, '0, 0, 1, 3);
    check("rd3_valid", cpu_rd_result_valid, 1'b1);
    check("rd3_data", cpu_rd_result, 32'd0);
    cycle(0, '0, 0, 1, 1);
    check("rd1_addr", cpu_rd_result[BA-1:0], 12'd8);

    rand_cycles(300);

    // Asynchronous reset mid-burst
    cycle(1, mk(50, 1), 0, 0, 0);
    cycle(1, mk(40, 2), 0, 0, 0);
    cycle(1, mk(60, 3), 1, 0, 0);
    check("pre_rst_valid", m_axis_valid, 1'b1);
    #3;
    rstn = 1'b0;
    #1;
    model_reset();
    check("arst_count", m_axis_calendar_count, 4'd0);
    check("arst_empty", m_axis_calendar_empty, 1'b1);
    check("arst_valid", m_axis_valid, 1'b0);
    check_all();
    @(negedge clk);
    rstn = 1'b1;
    #1;

    rand_cycles(150);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
